// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write-port bundle for the boot loader.
// The slave modport is the loader's view; the master modport is the view of
// the environment around it (byte source and memory sink).
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 6
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_waddr;
  logic [31:0]           imem_wdata;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  imem_we,
    input  imem_waddr,
    input  imem_wdata
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output imem_we,
    output imem_waddr,
    output imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader in front of instruction memory. It takes a length byte, then
// 4*N data bytes (MSB first per word), then an XOR checksum byte. Each packed
// word is written to imem. The CPU is held in reset until the image checks out.
module imem_loader #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_reset,
  output logic          done,
  output logic          error
);

  // word_idx needs one extra bit so a full-capacity image ends without wrap
  localparam int CNT_W    = ADDR_WIDTH + 1;
  localparam int CAPACITY = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t                state_r;
  logic                  rx_ready_r;
  logic                  imem_we_r;
  logic [ADDR_WIDTH-1:0] imem_waddr_r;
  logic [31:0]           imem_wdata_r;
  logic                  cpu_reset_r;
  logic                  done_r;
  logic                  error_r;
  logic [CNT_W-1:0]      word_cnt_r;
  logic [CNT_W-1:0]      word_idx_r;
  logic [1:0]            byte_idx_r;
  logic [23:0]           shift_r;
  logic [7:0]            csum_r;

  logic                  accept_s;
  logic [CNT_W-1:0]      word_idx_inc_s;

  // Running image checksum: XOR of every accepted data byte
  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // A length is usable only if it is non-zero and fits in memory
  function automatic logic len_ok(input logic [7:0] n);
    return (n != 8'd0) && (int'(n) <= CAPACITY);
  endfunction

  assign accept_s       = bus.rx_valid & rx_ready_r;
  assign word_idx_inc_s = word_idx_r + CNT_W'(1);

  assign bus.rx_ready   = rx_ready_r;
  assign bus.imem_we    = imem_we_r;
  assign bus.imem_waddr = imem_waddr_r;
  assign bus.imem_wdata = imem_wdata_r;
  assign cpu_reset      = cpu_reset_r;
  assign done           = done_r;
  assign error          = error_r;

  // Loader FSM: byte acceptance, word packing, memory writes and status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      rx_ready_r   <= 1'b0;
      imem_we_r    <= 1'b0;
      imem_waddr_r <= '0;
      imem_wdata_r <= 32'd0;
      cpu_reset_r  <= 1'b1;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      word_cnt_r   <= '0;
      word_idx_r   <= '0;
      byte_idx_r   <= 2'd0;
      shift_r      <= 24'd0;
      csum_r       <= 8'd0;
    end else begin
      // the write strobe is a single-cycle pulse unless re-armed below
      imem_we_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r    <= LEN;
            rx_ready_r <= 1'b1;
          end else begin
            rx_ready_r <= 1'b0;
          end
        end
        LEN: begin
          if (accept_s) begin
            if (len_ok(bus.rx_data)) begin
              state_r    <= DATA;
              word_cnt_r <= CNT_W'(bus.rx_data);
              word_idx_r <= '0;
              byte_idx_r <= 2'd0;
              shift_r    <= 24'd0;
              csum_r     <= 8'd0;
            end else begin
              state_r    <= ERR;
              rx_ready_r <= 1'b0;
              error_r    <= 1'b1;
            end
          end else begin
            state_r <= LEN;
          end
        end
        DATA: begin
          if (accept_s) begin
            csum_r <= csum_next(csum_r, bus.rx_data);
            if (byte_idx_r == 2'd3) begin
              imem_we_r    <= 1'b1;
              imem_waddr_r <= word_idx_r[ADDR_WIDTH-1:0];
              imem_wdata_r <= {shift_r, bus.rx_data};
              word_idx_r   <= word_idx_inc_s;
              byte_idx_r   <= 2'd0;
              if (word_idx_inc_s == word_cnt_r) begin
                state_r <= CSUM;
              end else begin
                state_r <= DATA;
              end
            end else begin
              shift_r    <= {shift_r[15:0], bus.rx_data};
              byte_idx_r <= byte_idx_r + 2'd1;
            end
          end else begin
            state_r <= DATA;
          end
        end
        CSUM: begin
          if (accept_s) begin
            rx_ready_r <= 1'b0;
            if (bus.rx_data == csum_r) begin
              state_r     <= DONE;
              done_r      <= 1'b1;
              cpu_reset_r <= 1'b0;
            end else begin
              state_r <= ERR;
              error_r <= 1'b1;
            end
          end else begin
            state_r <= CSUM;
          end
        end
        DONE, ERR: begin
          // a new start re-arms the loader and re-asserts CPU reset
          if (start) begin
            state_r     <= LEN;
            rx_ready_r  <= 1'b1;
            cpu_reset_r <= 1'b1;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
          end else begin
            rx_ready_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ERR;
          rx_ready_r  <= 1'b0;
          cpu_reset_r <= 1'b1;
          done_r      <= 1'b0;
          error_r     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives byte images through the stream port,
// records every instruction-memory write and compares against fixed images.
`timescale 1ns/1ps
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset_n;
  logic start;
  logic cpu_reset;
  logic done;
  logic error;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  imem_loader_if #(.ADDR_WIDTH(6)) bus ();

  imem_loader #(.ADDR_WIDTH(6)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // record each write strobe seen between clock edges
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_addr_q.push_back({26'd0, bus.imem_waddr});
      wr_data_q.push_back(bus.imem_wdata);
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the byte was taken
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check_value("rx_ready_wait", 32'(bus.rx_ready), 32'd1);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // the two-word reference image must appear at addresses 0 and 1
  task automatic check_two_words(input string tag, input logic [31:0] w0, input logic [31:0] w1);
    check_value({tag, "_nwr"}, 32'(wr_data_q.size()), 32'd2);
    if (wr_data_q.size() == 2) begin
      check_value({tag, "_a0"}, wr_addr_q[0], 32'd0);
      check_value({tag, "_d0"}, wr_data_q[0], w0);
      check_value({tag, "_a1"}, wr_addr_q[1], 32'd1);
      check_value({tag, "_d1"}, wr_data_q[1], w1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] img[8];
    img = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h0A, 8'h00, 8'h08};

    // reset asserted while start and a byte are offered
    reset_n      = 1'b0;
    start        = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hFF;
    repeat (3) @(negedge clk);
    check_value("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check_value("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    check_value("rst_done", 32'(done), 32'd0);
    check_value("rst_error", 32'(error), 32'd0);
    check_value("rst_no_write", 32'(wr_data_q.size()), 32'd0);
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    reset_n      = 1'b1;
    @(negedge clk);
    check_value("idle_rx_ready", 32'(bus.rx_ready), 32'd0);

    // good image; checksum = XOR of the eight data bytes = 0x27
    clear_writes();
    start_pulse();
    check_value("len_rx_ready", 32'(bus.rx_ready), 32'd1);
    send_byte(8'h02);
    send_word(32'h8C010004);
    send_word(32'hAC0A0008);
    check_value("pre_csum_done", 32'(done), 32'd0);
    check_value("pre_csum_cpu_reset", 32'(cpu_reset), 32'd1);
    send_byte(8'h27);
    check_value("good_done", 32'(done), 32'd1);
    check_value("good_cpu_reset", 32'(cpu_reset), 32'd0);
    check_value("good_rx_ready", 32'(bus.rx_ready), 32'd0);
    check_two_words("good", 32'h8C010004, 32'hAC0A0008);

    // bytes offered in DONE are ignored
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h55;
    repeat (3) @(negedge clk);
    bus.rx_valid = 1'b0;
    check_value("done_hold_ready", 32'(bus.rx_ready), 32'd0);
    check_value("done_hold_nwr", 32'(wr_data_q.size()), 32'd2);
    check_value("done_hold_done", 32'(done), 32'd1);

    // bad checksum, then recovery with the good image
    clear_writes();
    start_pulse();
    check_value("restart_done_clr", 32'(done), 32'd0);
    check_value("restart_cpu_reset", 32'(cpu_reset), 32'd1);
    send_byte(8'h02);
    send_word(32'h8C010004);
    send_word(32'hAC0A0008);
    send_byte(8'h2A);
    check_value("bad_error", 32'(error), 32'd1);
    check_value("bad_done", 32'(done), 32'd0);
    check_value("bad_cpu_reset", 32'(cpu_reset), 32'd1);
    check_value("bad_rx_ready", 32'(bus.rx_ready), 32'd0);
    clear_writes();
    start_pulse();
    check_value("err_restart_clr", 32'(error), 32'd0);
    send_byte(8'h02);
    send_word(32'h8C010004);
    send_word(32'hAC0A0008);
    send_byte(8'h27);
    check_value("recover_done", 32'(done), 32'd1);
    check_value("recover_error", 32'(error), 32'd0);
    check_two_words("recover", 32'h8C010004, 32'hAC0A0008);

    // length boundaries
    start_pulse();
    send_byte(8'h00);
    check_value("len0_error", 32'(error), 32'd1);
    start_pulse();
    send_byte(8'h41);
    check_value("len65_error", 32'(error), 32'd1);
    check_value("len65_cpu_reset", 32'(cpu_reset), 32'd1);

    // full capacity: word i holds bytes 4i..4i+3; XOR of 0..255 is 0x00
    clear_writes();
    start_pulse();
    send_byte(8'h40);
    for (int k = 0; k < 256; k++) begin
      send_byte(8'(k));
    end
    send_byte(8'h00);
    check_value("full_done", 32'(done), 32'd1);
    check_value("full_nwr", 32'(wr_data_q.size()), 32'd64);
    if (wr_data_q.size() == 64) begin
      check_value("full_first_data", wr_data_q[0], 32'h00010203);
      check_value("full_last_addr", wr_addr_q[63], 32'd63);
      check_value("full_last_data", wr_data_q[63], 32'hFCFDFEFF);
    end

    // valid gaps with start pulses in the middle of the data phase
    clear_writes();
    start_pulse();
    send_byte(8'h02);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < (i % 3); g++) begin
        start = ((i == 2) || (i == 5)) && (g == 0);
        @(negedge clk);
        start = 1'b0;
      end
      send_byte(img[i]);
    end
    check_value("gap_pre_csum_done", 32'(done), 32'd0);
    send_byte(8'h27);
    check_value("gap_done", 32'(done), 32'd1);
    check_value("gap_error", 32'(error), 32'd0);
    check_two_words("gap", 32'h8C010004, 32'hAC0A0008);

    // reset after six data bytes, then a fresh image
    clear_writes();
    start_pulse();
    send_byte(8'h02);
    for (int i = 0; i < 6; i++) begin
      send_byte(img[i]);
    end
    check_value("mid_nwr", 32'(wr_data_q.size()), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check_value("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check_value("mid_rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    clear_writes();
    start_pulse();
    send_byte(8'h02);
    send_word(32'h11223344);
    send_word(32'h55667788);
    // 11^22^33^44^55^66^77^88 = 0x88
    send_byte(8'h88);
    check_value("fresh_done", 32'(done), 32'd1);
    check_two_words("fresh", 32'h11223344, 32'h55667788);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
